// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU fetch definitions: FSM state encoding, PC increment and alignment helper.
package instr_fetch_unit_pkg;

  typedef logic [1:0] ifu_state_t;

  localparam ifu_state_t ST_IDLE = 2'd0;
  localparam ifu_state_t ST_REQ  = 2'd1;
  localparam ifu_state_t ST_DONE = 2'd2;
  localparam ifu_state_t ST_ERR  = 2'd3;

  localparam logic [31:0] PC_INCR = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one memory read per fetch_start and latches the word into ins_out.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ir_write,
  output logic [31:0] ins_out,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        align_err
);

  ifu_state_t  state;
  ifu_state_t  state_nxt;
  logic        accept_load;
  logic        accept_ack;

  // pc_load only counts while the unit is not in the middle of a fetch.
  assign accept_load = pc_load && ((state == ST_IDLE) || (state == ST_ERR));
  assign accept_ack  = mem_ack && (state == ST_REQ);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pc_load)
          state_nxt = ST_IDLE;
        else if (fetch_start)
          state_nxt = is_word_aligned(pc) ? ST_REQ : ST_ERR;
      end
      ST_REQ:  if (mem_ack) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  if (pc_load) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      ins_out <= '0;
    end else begin
      state <= state_nxt;
      if (accept_load)
        pc <= pc_next;
      else if (accept_ack)
        pc <= pc_plus4;
      if (accept_ack)
        ins_out <= mem_rdata;
    end
  end

  assign pc_plus4  = pc + PC_INCR;
  assign mem_req   = (state == ST_REQ);
  assign mem_addr  = pc;
  assign ir_write  = (state == ST_DONE);
  assign busy      = (state == ST_REQ) || (state == ST_DONE);
  assign align_err = (state == ST_ERR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a transaction-level reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst, fetch_start, pc_load, mem_ack;
  logic [31:0] pc_next, mem_rdata;
  logic        mem_req, ir_write, busy, align_err;
  logic [31:0] mem_addr, ins_out, pc, pc_plus4;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: a fetch is either outstanding, just completed, or blocked by a misaligned PC.
  bit          m_waiting, m_completed, m_faulted;
  logic [31:0] m_pc, m_ins;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_next(pc_next), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ir_write(ir_write), .ins_out(ins_out), .pc(pc),
    .pc_plus4(pc_plus4), .busy(busy), .align_err(align_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fs, input logic pl, input logic [31:0] pn,
                       input logic ack, input logic [31:0] rd);
    rst = r; fetch_start = fs; pc_load = pl; pc_next = pn; mem_ack = ack; mem_rdata = rd;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_waiting = 0; m_completed = 0; m_faulted = 0; m_pc = RST_PC; m_ins = '0;
    end else if (m_waiting) begin
      if (mem_ack) begin
        m_ins = mem_rdata; m_pc = m_pc + 32'd4; m_waiting = 0; m_completed = 1;
      end
    end else if (m_completed) begin
      m_completed = 0;
    end else if (pc_load) begin
      m_pc = pc_next; m_faulted = 0;
    end else if (fetch_start && !m_faulted) begin
      if (m_pc % 4 == 0) m_waiting = 1;
      else m_faulted = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("mem_req",   {31'd0, mem_req},   {31'd0, m_waiting});
    if (m_waiting) chk("mem_addr", mem_addr, m_pc);
    chk("ir_write",  {31'd0, ir_write},  {31'd0, m_completed});
    chk("busy",      {31'd0, busy},      {31'd0, m_waiting | m_completed});
    chk("align_err", {31'd0, align_err}, {31'd0, m_faulted});
    chk("pc",        pc,       m_pc);
    chk("pc_plus4",  pc_plus4, m_pc + 32'd4);
    chk("ins_out",   ins_out,  m_ins);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, '0, 0, '0);
      step();
    end
  endtask

  initial begin
    logic [31:0] rnd;
    drive(1, 0, 0, '0, 0, '0);
    step();
    chk("reset_pc", pc, RST_PC);
    chk("reset_ins", ins_out, 32'h0);

    // Basic fetch, ack in second REQ cycle
    drive(0, 0, 1, 32'h0, 0, '0); step();
    drive(0, 1, 0, '0, 0, '0); step();
    drive(0, 0, 0, '0, 0, 32'h1111_1111); step();
    drive(0, 0, 0, '0, 1, 32'h2008_0005); step();
    chk("fetch_ir_write", {31'd0, ir_write}, 32'd1);
    chk("fetch_ins", ins_out, 32'h2008_0005);
    chk("fetch_pc", pc, 32'h4);
    idle_steps(2);

    // Misaligned PC latches ERR, sticky until pc_load
    drive(0, 0, 1, 32'h0000_0042, 0, '0); step();
    drive(0, 1, 0, '0, 0, '0); step();
    chk("misalign_err", {31'd0, align_err}, 32'd1);
    drive(0, 1, 0, '0, 1, 32'hDEAD_BEEF); step();
    drive(0, 1, 0, '0, 0, '0); step();
    drive(0, 0, 1, 32'h40, 0, '0); step();
    chk("err_cleared", {31'd0, align_err}, 32'd0);

    // PC wrap
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, '0); step();
    drive(0, 1, 0, '0, 0, '0); step();
    drive(0, 0, 0, '0, 1, 32'hCAFE_0001); step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc_plus4", pc_plus4, 32'h4);
    idle_steps(1);

    // Long ack with ignored pulses mid-fetch
    drive(0, 1, 0, '0, 0, '0); step();
    for (int i = 0; i < 10; i++) begin
      drive(0, (i == 3), (i == 5), 32'h0000_0800, 0, '0);
      step();
    end
    drive(0, 0, 0, '0, 1, 32'h0BAD_F00D); step();
    idle_steps(3);

    // Reset mid-fetch, late ack ignored
    drive(0, 1, 0, '0, 0, '0); step();
    drive(1, 0, 0, '0, 0, '0); step();
    drive(0, 0, 0, '0, 1, 32'h5555_AAAA); step();
    chk("rst_mid_ins", ins_out, 32'h0);
    chk("rst_mid_pc", pc, RST_PC);
    idle_steps(1);

    // pc_load beats fetch_start
    drive(0, 1, 1, 32'h100, 0, '0); step();
    chk("load_wins_pc", pc, 32'h100);
    drive(0, 0, 0, '0, 0, '0); step();
    chk("load_wins_noreq", {31'd0, mem_req}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0) ? rnd : {rnd[31:2], 2'b00},
            ($urandom_range(0, 2) == 0),
            $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
